// File: rtl/apb_i2c_pkg.sv
// Shared register map, STATUS/INT_STAT bit positions and interrupt width
// for the APB-to-I2C register bank.
package apb_i2c_pkg;

    localparam logic [4:0] OFF_TXDATA   = 5'h00;
    localparam logic [4:0] OFF_RXDATA   = 5'h04;
    localparam logic [4:0] OFF_CONFIG   = 5'h08;
    localparam logic [4:0] OFF_TIMEOUT  = 5'h0C;
    localparam logic [4:0] OFF_STATUS   = 5'h10;
    localparam logic [4:0] OFF_INT_EN   = 5'h14;
    localparam logic [4:0] OFF_INT_STAT = 5'h18;

    localparam int ST_TX_EMPTY     = 0;
    localparam int ST_TX_FULL      = 1;
    localparam int ST_RX_EMPTY     = 2;
    localparam int ST_RX_FULL      = 3;
    localparam int ST_TX_COUNT_LSB = 8;
    localparam int ST_RX_COUNT_LSB = 16;
    localparam int ST_COUNT_W      = 8;

    localparam int INT_W        = 4;
    localparam int INT_TX_EMPTY = 0;
    localparam int INT_RX_AVAIL = 1;
    localparam int INT_RX_OVF   = 2;
    localparam int INT_ERR      = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; callers qualify push/pop so a
// push is never issued into a full FIFO unless a pop shares the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/apb_i2c_regbank.sv
// APB3 zero-wait-state register bank for an I2C core: TX/RX FIFOs,
// CONFIG/TIMEOUT registers and a sticky, maskable interrupt block.
module apb_i2c_regbank
    import apb_i2c_pkg::*;
#(
    parameter int CFG_W      = 14,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSELx,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              core_error,
    output logic [CFG_W-1:0]  cfg,
    output logic [CFG_W-1:0]  timeout,
    output logic              irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              access;
    logic              err;
    logic [31:0]       rdata;
    logic [31:0]       status;
    logic              tx_push, tx_pop, rx_push, rx_pop;
    logic              cfg_we, tmo_we, ien_we, ist_we;
    logic [DATA_W-1:0] tx_head, rx_head;
    logic [CW-1:0]     tx_count, rx_count;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [CFG_W-1:0]  cfg_q, tmo_q;
    logic [INT_W-1:0]  ien_q, ist_q, ist_next, ev;
    logic              core_error_p1;
    logic              irq_p1;
    logic              unused_pwdata;

    assign unused_pwdata = ^PWDATA;
    assign access        = PSELx & PENABLE;

    always_comb begin
        status = '0;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_TX_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(tx_count);
        status[ST_RX_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(rx_count);
    end

    // Address decode: any error suppresses every write enable and FIFO strobe.
    always_comb begin
        rdata   = '0;
        err     = 1'b0;
        tx_push = 1'b0;
        rx_pop  = 1'b0;
        cfg_we  = 1'b0;
        tmo_we  = 1'b0;
        ien_we  = 1'b0;
        ist_we  = 1'b0;
        if (access) begin
            if (|PADDR[31:5]) begin
                err = 1'b1;
            end else begin
                case (PADDR[4:0])
                    OFF_TXDATA:   if (!PWRITE || tx_full) err = 1'b1; else tx_push = 1'b1;
                    OFF_RXDATA:   if (PWRITE || rx_empty) err = 1'b1;
                                  else begin rx_pop = 1'b1; rdata = 32'(rx_head); end
                    OFF_CONFIG:   if (PWRITE) cfg_we = 1'b1; else rdata = 32'(cfg_q);
                    OFF_TIMEOUT:  if (PWRITE) tmo_we = 1'b1; else rdata = 32'(tmo_q);
                    OFF_STATUS:   if (PWRITE) err = 1'b1; else rdata = status;
                    OFF_INT_EN:   if (PWRITE) ien_we = 1'b1; else rdata = 32'(ien_q);
                    OFF_INT_STAT: if (PWRITE) ist_we = 1'b1; else rdata = 32'(ist_q);
                    default:      err = 1'b1;
                endcase
            end
        end
    end

    assign tx_pop  = tx_ready & ~tx_empty;
    assign rx_push = rx_valid & (~rx_full | rx_pop);

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(PCLK), .rst_n(PRESETn), .push(tx_push), .push_data(PWDATA[DATA_W-1:0]),
        .pop(tx_pop), .head(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(PCLK), .rst_n(PRESETn), .push(rx_push), .push_data(rx_data),
        .pop(rx_pop), .head(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
    );

    // Set events are computed from next-state so they land on the same edge
    // as the FIFO transition; a set always beats a same-cycle W1C.
    always_comb begin
        ev               = '0;
        ev[INT_TX_EMPTY] = tx_pop & ~tx_push & (tx_count == CW'(1));
        ev[INT_RX_AVAIL] = rx_push & rx_empty;
        ev[INT_RX_OVF]   = rx_valid & rx_full & ~rx_pop;
        ev[INT_ERR]      = core_error & ~core_error_p1;
        ist_next         = (ist_q & ~(ist_we ? PWDATA[INT_W-1:0] : '0)) | ev;
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            cfg_q         <= '0;
            tmo_q         <= '0;
            ien_q         <= '0;
            ist_q         <= '0;
            core_error_p1 <= 1'b0;
            irq_p1        <= 1'b0;
        end else begin
            if (cfg_we) cfg_q <= PWDATA[CFG_W-1:0];
            if (tmo_we) tmo_q <= PWDATA[CFG_W-1:0];
            if (ien_we) ien_q <= PWDATA[INT_W-1:0];
            ist_q         <= ist_next;
            core_error_p1 <= core_error;
            irq_p1        <= |(ist_q & ien_q);
        end
    end

    assign PRDATA   = rdata;
    assign PREADY   = access;
    assign PSLVERR  = err;
    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_head;
    assign cfg      = cfg_q;
    assign timeout  = tmo_q;
    assign irq      = irq_p1;

endmodule

// File: tb/tb_apb_i2c_regbank.sv
// Scenario-per-task bench for apb_i2c_regbank; FIFO traffic is tracked with
// expected-data queues filled on accepted pushes and drained on pops.
module tb_apb_i2c_regbank;

    logic        PCLK = 1'b0;
    logic        PRESETn, PSELx, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic        tx_valid, tx_ready, rx_valid, core_error, irq;
    logic [7:0]  tx_data, rx_data;
    logic [13:0] cfg, timeout;

    int checks = 0;
    int errors = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    always #5 PCLK = ~PCLK;

    apb_i2c_regbank #(.CFG_W(14), .DATA_W(8), .FIFO_DEPTH(8)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .core_error(core_error),
        .cfg(cfg), .timeout(timeout), .irq(irq)
    );

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err, output logic rdy);
        @(negedge PCLK); PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        @(negedge PCLK); PENABLE = 1'b1;
        #1 data = PRDATA; err = PSLVERR; rdy = PREADY;
        @(negedge PCLK); PSELx = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] wdata, output logic err);
        @(negedge PCLK); PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = wdata;
        @(negedge PCLK); PENABLE = 1'b1;
        #1 err = PSLVERR;
        @(negedge PCLK); PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic core_push(input logic [7:0] d);
        rx_valid = 1'b1; rx_data = d;
        @(negedge PCLK); rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e, r;
        PRESETn = 1'b0;
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        checks++; if (PRDATA !== 32'h0) begin errors++; $display("FAIL reset_prdata got %h want 0", PRDATA); end
        checks++; if (PREADY !== 1'b0 || PSLVERR !== 1'b0) begin errors++; $display("FAIL reset_ready_err got %b%b want 00", PREADY, PSLVERR); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
        checks++; if (cfg !== 14'h0 || timeout !== 14'h0) begin errors++; $display("FAIL reset_cfg got %h/%h want 0/0", cfg, timeout); end
        apb_read(32'h10, d, e, r);
        checks++; if (d !== 32'h5 || e !== 1'b0 || r !== 1'b1) begin errors++; $display("FAIL reset_status got %h err %b rdy %b want 00000005 0 1", d, e, r); end
        apb_read(32'h18, d, e, r);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_int_stat got %h want 0", d); end
    endtask

    task automatic test_config();
        logic [31:0] d; logic e, r;
        apb_write(32'h08, 32'hFFFF_FFFF, e);
        checks++; if (cfg !== 14'h3FFF || e !== 1'b0) begin errors++; $display("FAIL cfg_out got %h err %b want 3fff 0", cfg, e); end
        apb_read(32'h08, d, e, r);
        checks++; if (d !== 32'h3FFF) begin errors++; $display("FAIL cfg_read got %h want 00003fff", d); end
        apb_write(32'h0C, 32'h0001_2345, e);
        apb_read(32'h0C, d, e, r);
        checks++; if (d !== 32'h2345 || timeout !== 14'h2345) begin errors++; $display("FAIL timeout got %h/%h want 2345", d, timeout); end
    endtask

    task automatic test_access_errors();
        logic [31:0] d; logic e, r;
        apb_write(32'h10, 32'hFFFF_FFFF, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_wr_status got %b want 1", e); end
        apb_write(32'h04, 32'h0, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_wr_rxdata got %b want 1", e); end
        apb_read(32'h00, d, e, r);
        checks++; if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL err_rd_txdata got err %b data %h want 1 0", e, d); end
        apb_read(32'h1C, d, e, r);
        checks++; if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL err_unmapped got err %b data %h want 1 0", e, d); end
        apb_write(32'h0000_0108, 32'h0, e);
        checks++; if (e !== 1'b1 || cfg !== 14'h3FFF) begin errors++; $display("FAIL err_high_addr got err %b cfg %h want 1 3fff", e, cfg); end
        apb_read(32'h0000_0048, d, e, r);
        checks++; if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL err_high_rd got err %b data %h want 1 0", e, d); end
        apb_write(32'h00, 32'h77, e);
        apb_read(32'h10, d, e, r);
        checks++; if (d !== 32'h0000_0104) begin errors++; $display("FAIL one_push_status got %h want 00000104", d); end
        tx_q.push_back(8'h77);
        tx_ready = 1'b1;
        #1 checks++; if (tx_data !== tx_q.pop_front()) begin errors++; $display("FAIL one_pop_data got %h want 77", tx_data); end
        @(negedge PCLK); tx_ready = 1'b0;
        apb_write(32'h18, 32'hF, e);
    endtask

    task automatic test_tx_fill_drain();
        logic [31:0] d; logic e, r; logic [7:0] exp;
        for (int i = 0; i < 8; i++) begin
            apb_write(32'h00, 32'hFFFF_FF11 + i, e);
            if (e === 1'b0) tx_q.push_back(8'h11 + 8'(i));
        end
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin errors++; $display("FAIL tx_head got %b %h want 1 11", tx_valid, tx_data); end
        apb_write(32'h00, 32'h99, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL tx_ninth got err %b want 1", e); end
        apb_read(32'h10, d, e, r);
        checks++; if (d !== 32'h0000_0806) begin errors++; $display("FAIL tx_full_status got %h want 00000806", d); end
        // push into a full TX in the same cycle as a core pop must still be refused
        @(negedge PCLK); PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'hAA;
        @(negedge PCLK); PENABLE = 1'b1; tx_ready = 1'b1;
        #1 exp = tx_q.pop_front();
        checks++; if (PSLVERR !== 1'b1 || tx_data !== exp) begin errors++; $display("FAIL tx_full_pop_push got err %b data %h want 1 %h", PSLVERR, tx_data, exp); end
        @(negedge PCLK); PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; tx_ready = 1'b0;
        apb_read(32'h10, d, e, r);
        checks++; if (d !== 32'h0000_0704) begin errors++; $display("FAIL tx_after_pop_status got %h want 00000704", d); end
        tx_ready = 1'b1;
        for (int i = 0; i < 16 && tx_q.size() > 0; i++) begin
            #1 exp = tx_q.pop_front();
            checks++; if (tx_valid !== 1'b1 || tx_data !== exp) begin errors++; $display("FAIL tx_drain got %b %h want 1 %h", tx_valid, tx_data, exp); end
            @(negedge PCLK);
        end
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_empty_valid got %b want 0", tx_valid); end
        apb_read(32'h18, d, e, r);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL tx_empty_int got %h want 1", d); end
    endtask

    task automatic test_rx_overflow();
        logic [31:0] d; logic e, r;
        apb_write(32'h18, 32'hF, e);
        apb_write(32'h14, 32'h4, e);
        for (int i = 0; i < 9; i++) begin
            core_push(8'h31 + 8'(i));
            if (i < 8) rx_q.push_back(8'h31 + 8'(i));
        end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b want 0", irq); end
        @(negedge PCLK);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b want 1", irq); end
        apb_read(32'h18, d, e, r);
        checks++; if (d !== 32'h6) begin errors++; $display("FAIL rx_ovf_int got %h want 6", d); end
        apb_read(32'h10, d, e, r);
        checks++; if (d !== 32'h0008_0009) begin errors++; $display("FAIL rx_full_status got %h want 00080009", d); end
        apb_write(32'h18, 32'h4, e);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got %b want 1", irq); end
        @(negedge PCLK);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic e, r; logic [7:0] exp;
        @(negedge PCLK); PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h04;
        @(negedge PCLK); PENABLE = 1'b1; rx_valid = 1'b1; rx_data = 8'hA5;
        #1 exp = rx_q.pop_front();
        checks++; if (PRDATA !== {24'h0, exp} || PSLVERR !== 1'b0) begin errors++; $display("FAIL rx_pop_push got %h err %b want %h 0", PRDATA, PSLVERR, exp); end
        rx_q.push_back(8'hA5);
        @(negedge PCLK); PSELx = 1'b0; PENABLE = 1'b0; rx_valid = 1'b0;
        apb_read(32'h10, d, e, r);
        checks++; if (d !== 32'h0008_0009) begin errors++; $display("FAIL rx_simul_status got %h want 00080009", d); end
        apb_read(32'h18, d, e, r);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL rx_simul_int got %h want 2", d); end
        for (int i = 0; i < 16 && rx_q.size() > 0; i++) begin
            apb_read(32'h04, d, e, r);
            exp = rx_q.pop_front();
            checks++; if (d !== {24'h0, exp} || e !== 1'b0) begin errors++; $display("FAIL rx_drain got %h err %b want %h 0", d, e, exp); end
        end
        apb_read(32'h04, d, e, r);
        checks++; if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL rx_empty_read got err %b data %h want 1 0", e, d); end
    endtask

    task automatic test_err_w1c();
        logic [31:0] d; logic e, r;
        apb_write(32'h18, 32'hF, e);
        @(negedge PCLK); PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h18; PWDATA = 32'h8;
        @(negedge PCLK); PENABLE = 1'b1; core_error = 1'b1;
        @(negedge PCLK); PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        apb_read(32'h18, d, e, r);
        checks++; if (d !== 32'h8) begin errors++; $display("FAIL err_set_wins got %h want 8", d); end
        apb_write(32'h18, 32'h8, e);
        apb_read(32'h18, d, e, r);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL err_level_no_reset got %h want 0", d); end
        core_error = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL err_masked_irq got %b want 0", irq); end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] d; logic e, r;
        apb_write(32'h00, 32'h55, e);
        core_push(8'h66);
        apb_write(32'h08, 32'h5, e);
        @(negedge PCLK); PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h00; PWDATA = 32'h56;
        @(negedge PCLK); PENABLE = 1'b1; PRESETn = 1'b0;
        @(negedge PCLK); PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        @(negedge PCLK); PRESETn = 1'b1;
        tx_q.delete(); rx_q.delete();
        checks++; if (tx_valid !== 1'b0 || cfg !== 14'h0) begin errors++; $display("FAIL midreset_state got %b %h want 0 0", tx_valid, cfg); end
        apb_read(32'h10, d, e, r);
        checks++; if (d !== 32'h5) begin errors++; $display("FAIL midreset_status got %h want 5", d); end
        apb_read(32'h18, d, e, r);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_int got %h want 0", d); end
    endtask

    initial begin
        PRESETn = 1'b0; PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0; core_error = 1'b0;
        test_reset();
        test_config();
        test_access_errors();
        test_tx_fill_drain();
        test_rx_overflow();
        test_back_to_back();
        test_err_w1c();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_i2c_regbank.md
APB_I2C_REGBANK -- requirements
Module: apb_i2c_regbank

Interface
REQ-001 Parameters SHALL be, one per line:
  CFG_W, 14, width of CONFIG and TIMEOUT registers (1..32)
  DATA_W, 8, width of one TX/RX FIFO entry (1..32)
  FIFO_DEPTH, 8, entries per FIFO, power of two, at least 2
REQ-002 Ports SHALL be, one per line:
  PCLK  in  1  sole clock; all logic on its rising edge
  PRESETn  in  1  synchronous, active-low reset
  PSELx  in  1  APB select
  PENABLE  in  1  APB access phase
  PWRITE  in  1  1 = write
  PADDR  in  32  byte address; only bits [4:0] decoded, bits [31:5] must be 0
  PWDATA  in  32  write data
  PRDATA  out  32  read data
  PREADY  out  1  transfer complete
  PSLVERR  out  1  transfer error
  tx_valid  out  1  TX FIFO non-empty
  tx_data  out  DATA_W  TX FIFO head
  tx_ready  in  1  core pops TX head when tx_valid is also 1
  rx_valid  in  1  core pushes rx_data
  rx_data  in  DATA_W  received byte
  core_error  in  1  I2C core error level
  cfg  out  CFG_W  CONFIG register
  timeout  out  CFG_W  TIMEOUT register
  irq  out  1  OR of enabled pending interrupts

Function
REQ-003 Access phase (PSELx & PENABLE) SHALL assert PREADY=1 in the same cycle (zero wait states); PREADY=0 otherwise.
REQ-004 Register map SHALL be: 0x00 TXDATA (W), 0x04 RXDATA (R), 0x08 CONFIG (RW), 0x0C TIMEOUT (RW), 0x10 STATUS (R), 0x14 INT_EN (RW, bits [3:0]), 0x18 INT_STAT (R, W1C, bits [3:0]).
REQ-005 PSLVERR SHALL be 1 during the access phase for: an unmapped address; PADDR[31:5] non-zero; a write to RXDATA or STATUS; a read of TXDATA; a TXDATA write while TX is full; an RXDATA read while RX is empty. An errored access SHALL change no state.
REQ-006 A TXDATA write SHALL push PWDATA[DATA_W-1:0] at the access-phase edge. An RXDATA read SHALL return the zero-extended RX head combinationally and pop it at the same edge.
REQ-007 CONFIG and TIMEOUT writes SHALL load PWDATA[CFG_W-1:0] at the access-phase edge. cfg and timeout SHALL mirror the registers.
REQ-008 STATUS SHALL be: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [15:8] tx_count, [23:16] rx_count. Counts SHALL range 0..FIFO_DEPTH and be zero-extended.
REQ-009 Unmapped bits and idle cycles SHALL read PRDATA=0.
REQ-010 The core SHALL pop TX when tx_valid & tx_ready. When TX is full, an APB push SHALL be rejected even if a core pop occurs in the same cycle.
REQ-011 A core push (rx_valid) with RX not full SHALL store rx_data. With RX full and no APB pop in the same cycle, the data SHALL be dropped and RX_OVF set. With RX full and an APB pop in the same cycle, the push SHALL be accepted.
REQ-012 INT_STAT bits SHALL be sticky: [0] TX_EMPTY, set on the TX transition non-empty->empty; [1] RX_AVAIL, set on the RX transition empty->non-empty; [2] RX_OVF; [3] ERR, set on the core_error rising edge (registered previous value).
REQ-013 Writing 1 to an INT_STAT bit SHALL clear it. A set event in the same cycle SHALL win.
REQ-014 irq SHALL be the registered value of |(INT_STAT & INT_EN): one cycle after the status/enable update, glitch-free.
REQ-015 Pointers SHALL wrap modulo FIFO_DEPTH. Full/empty SHALL be derived from a count of width $clog2(FIFO_DEPTH)+1.

Reset
REQ-016 While PRESETn=0 at a PCLK edge, the following SHALL be cleared to 0: CONFIG, TIMEOUT, INT_EN, INT_STAT, FIFO pointers, FIFO counts, irq and the core_error history.
REQ-017 After reset: tx_valid=0, STATUS=0x0000_0005, PRDATA=0, PREADY=0, PSLVERR=0.
REQ-018 A reset mid-transfer or with data in the FIFOs SHALL discard all FIFO contents. The reset SHALL not generate TX_EMPTY.
REQ-019 FIFO storage arrays SHALL need no reset.

Structure
REQ-020 Package apb_i2c_pkg SHALL hold the register offset constants, the STATUS and INT_STAT bit-index constants, and the INT_STAT width.
REQ-021 Both FIFOs SHALL be instances of one sub-module, sync_fifo (parameters WIDTH, DEPTH), which exports count, full, empty and head.

Verification
REQ-022 Reset, then read 0x10 -> PRDATA=0x0000_0005, PSLVERR=0; irq=0.
REQ-023 Write 0x08 with 0xFFFF_FFFF (CFG_W=14) -> cfg=0x3FFF; read 0x08 returns 0x0000_3FFF.
REQ-024 Eight TXDATA writes 0x11..0x18, then a ninth -> ninth PSLVERR=1; STATUS[15:8]=8; tx_ready=1 for 8 cycles -> tx_data 0x11..0x18 in order; INT_STAT[0]=1.
REQ-025 Nine rx_valid pushes into an empty RX with no reads -> INT_STAT=0x6; with INT_EN=0x4, irq=1 one cycle later; W1C 0x4 -> irq=0; ninth byte absent on readback.
REQ-026 RX full, RXDATA read and rx_valid in the same cycle -> no overflow; rx_count stays 8.
REQ-027 core_error rising in the same cycle as a W1C of bit 3 -> INT_STAT[3]=1; read 0x04 with RX empty -> PSLVERR=1, PRDATA=0.
